sb_rx_msg_decoder: RTL

SB_RX_MSG_DECODER -- requirements
Module: sb_rx_msg_decoder

---
 rtl/sb_rx_msg_decoder_pkg.sv | 48 ++++
 rtl/sb_msg_fifo.sv | 69 ++++++
 rtl/sb_rx_msg_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sb_rx_msg_decoder_pkg.sv
// rtl/sb_rx_msg_decoder_pkg.sv - shared SB codex: packet field map, opcodes, msgcodes, message type
//
// Purpose: single home for sideband packet layout constants and the decoded
// message record shared by the decoder, its queue and the testbench.
// Ports: none (package).

package sb_rx_msg_decoder_pkg;

    // Packet field positions within the 64-bit deserialized sideband word
    localparam int OPC_LSB     = 0;
    localparam int OPC_W       = 5;
    localparam int MSGCODE_LSB = 14;
    localparam int SUBCODE_LSB = 32;
    localparam int INFO_LSB    = 40;
    localparam int CP_BIT      = 62;
    localparam int DP_BIT      = 63;

    // Only message-without-data packets are decoded by this block
    localparam logic [OPC_W-1:0] OPC_MSG_NODATA = 5'b10010;

    // Message codes and subcodes seen by the link training state machine
    localparam logic [7:0] MSGCODE_MBINIT_REQ      = 8'h85;
    localparam logic [7:0] MSGCODE_MBINIT_RSP      = 8'h8A;
    localparam logic [7:0] MSGCODE_SBINIT_DONE_REQ = 8'h95;
    localparam logic [7:0] MSGCODE_SBINIT_DONE_RSP = 8'h9A;
    localparam logic [7:0] SUBCODE_PARAM           = 8'h00;
    localparam logic [7:0] SUBCODE_CAL             = 8'h01;
    localparam logic [7:0] SUBCODE_REPAIRCLK       = 8'h02;

    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  subcode;
        logic [15:0] info;
    } sb_msg_t;

    localparam int SB_MSG_W = $bits(sb_msg_t);

    typedef enum logic {
        WD_IDLE,
        WD_ARMED
    } wd_state_t;

    // Good when control parity makes bits [62:0] XOR to zero and no data parity is flagged
    function automatic logic parity_good(input logic [63:0] word);
        return (~(^word[CP_BIT:0])) & ~word[DP_BIT];
    endfunction

endpackage

// File: rtl/sb_msg_fifo.sv
// rtl/sb_msg_fifo.sv - first-word fall-through queue for decoded sideband messages
//
// Purpose: circular buffer with extended pointers; head data is visible as soon
// as the queue is non-empty. Push and pop in the same cycle both take effect,
// including when full (the freed slot is refilled).
// Ports:
//   clk_100MHz  in   clock
//   reset       in   asynchronous active-high, empties the queue
//   push        in   write push_data (ignored when full without a pop)
//   push_data   in   WIDTH-bit entry
//   pop         in   retire head (ignored when empty)
//   head_data   out  current head entry (meaningful only while !empty)
//   empty, full out  occupancy flags

module sb_msg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bit means every slot is occupied
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_data = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk_100MHz) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sb_rx_msg_decoder.sv
// rtl/sb_rx_msg_decoder.sv - sideband receive message decoder with drop accounting and response watchdog
//
// Purpose: checks parity and opcode of each received sideband packet, queues
// decoded message fields for the LTSM, reports why packets are dropped, and
// runs a response watchdog that a decoded message cancels.
// Ports:
//   clk_100MHz     in   clock
//   reset          in   asynchronous active-high
//   rx_word_i      in   64-bit packet, qualified by rx_valid_i
//   rx_valid_i     in   one-cycle packet strobe
//   msg_valid_o    out  queue head valid
//   msg_ready_i    in   LTSM consumes head
//   msg_code_o     out  head msgcode
//   msg_subcode_o  out  head msgsubcode
//   msg_info_o     out  head msginfo
//   timer_start_i  in   arm / re-arm watchdog
//   timer_stop_i   in   disarm watchdog
//   timeout_o      out  one-cycle expiry pulse
//   parity_err_o   out  drop pulse: bad parity
//   unsupported_o  out  drop pulse: opcode not handled
//   overflow_o     out  drop pulse: queue full
//   err_count_o    out  saturating dropped-packet count

module sb_rx_msg_decoder
    import sb_rx_msg_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [63:0] rx_word_i,
    input  logic        rx_valid_i,
    output logic        msg_valid_o,
    input  logic        msg_ready_i,
    output logic [7:0]  msg_code_o,
    output logic [7:0]  msg_subcode_o,
    output logic [15:0] msg_info_o,
    input  logic        timer_start_i,
    input  logic        timer_stop_i,
    output logic        timeout_o,
    output logic        parity_err_o,
    output logic        unsupported_o,
    output logic        overflow_o,
    output logic [7:0]  err_count_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Packet decode
    logic             par_ok;
    logic             supported;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             blocked;
    logic             push;
    sb_msg_t          rx_msg;
    sb_msg_t          head_msg;

    assign par_ok    = parity_good(rx_word_i);
    assign supported = (rx_word_i[OPC_LSB +: OPC_W] == OPC_MSG_NODATA);

    assign rx_msg.code    = rx_word_i[MSGCODE_LSB +: 8];
    assign rx_msg.subcode = rx_word_i[SUBCODE_LSB +: 8];
    assign rx_msg.info    = rx_word_i[INFO_LSB +: 16];

    assign pop     = ~fifo_empty & msg_ready_i;
    // A full queue still accepts when the head leaves in the same cycle
    assign blocked = fifo_full & ~pop;
    assign push    = rx_valid_i & par_ok & supported & ~blocked;

    sb_msg_fifo #(
        .WIDTH (SB_MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .push       (push),
        .push_data  (rx_msg),
        .pop        (pop),
        .head_data  (head_msg),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // Fields are forced to zero whenever there is no head so stale storage never leaks out
    assign msg_valid_o   = ~fifo_empty;
    assign msg_code_o    = msg_valid_o ? head_msg.code    : 8'h00;
    assign msg_subcode_o = msg_valid_o ? head_msg.subcode : 8'h00;
    assign msg_info_o    = msg_valid_o ? head_msg.info    : 16'h0000;

    // Drop reasons, mutually exclusive by priority, reported the cycle after the strobe
    logic par_err_q;
    logic unsup_q;
    logic ovf_q;
    logic [7:0] err_cnt_q;
    logic       drop;

    assign drop = rx_valid_i & ~push;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            par_err_q <= 1'b0;
            unsup_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            par_err_q <= rx_valid_i & ~par_ok;
            unsup_q   <= rx_valid_i & par_ok & ~supported;
            ovf_q     <= rx_valid_i & par_ok & supported & blocked;
            if (drop && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'h01;
            end
        end
    end

    assign parity_err_o  = par_err_q;
    assign unsupported_o = unsup_q;
    assign overflow_o    = ovf_q;
    assign err_count_o   = err_cnt_q;

    // Response watchdog
    wd_state_t        wd_state_q;
    wd_state_t        wd_state_d;
    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wd_state_q <= WD_IDLE;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wd_state_q <= wd_state_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Start has priority so a re-arm in the same cycle as the awaited response keeps waiting.
    // Only an accepted message counts as a response; dropped packets leave the timer running.
    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = 1'b0;
        if (timer_start_i) begin
            wd_state_d = WD_ARMED;
            wd_cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (wd_state_q == WD_ARMED) begin
            if (push || timer_stop_i) begin
                wd_state_d = WD_IDLE;
            end else if (wd_cnt_q == '0) begin
                wd_state_d = WD_IDLE;
                timeout_d  = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q - 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;

endmodule
